alu16_seq: RTL and testbench

ALU16_SEQ -- requirements
Module: alu16_seq

---
 rtl/alu16_pkg.sv | 27 ++
 rtl/alu16_byte_mux.sv | 35 +++
 rtl/alu16_seq.sv | 110 +++++++++++
 tb/tb_alu16_seq.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu16_pkg.sv
// rtl/alu16_pkg.sv - op encodings and sequencer states for the byte-serial 16-bit ALU
package alu16_pkg;

    localparam logic [1:0] OP_ADD16 = 2'b00;
    localparam logic [1:0] OP_INC16 = 2'b01;
    localparam logic [1:0] OP_DEC16 = 2'b10;
    localparam logic [1:0] OP_ADDSP = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LO   = 2'b01,
        HI   = 2'b10,
        DONE = 2'b11
    } state_t;

    // Effective B operand: constant one for INC/DEC, sign-extended byte for ADDSP.
    function automatic logic [15:0] effective_b(input logic [1:0] op, input logic [15:0] opb);
        logic [15:0] b;
        case (op)
            OP_INC16, OP_DEC16: b = 16'h0001;
            OP_ADDSP:           b = {{8{opb[7]}}, opb[7:0]};
            default:            b = opb;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/alu16_byte_mux.sv
// rtl/alu16_byte_mux.sv - selects byte operands, carry-in and subtract mode for the shared 8-bit ALU
module alu16_byte_mux
    import alu16_pkg::*;
(
    input  logic        active,
    input  logic        sel_hi,
    input  logic [1:0]  op,
    input  logic [15:0] opa,
    input  logic [15:0] opb,
    input  logic        c_lo,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic        alu_cin,
    output logic        alu_sub
);

    logic [15:0] b_eff;

    assign b_eff = effective_b(op, opb);

    // Everything is forced to zero outside the two ALU-owning states.
    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        alu_cin = 1'b0;
        alu_sub = 1'b0;
        if (active) begin
            alu_a   = sel_hi ? opa[15:8]   : opa[7:0];
            alu_b   = sel_hi ? b_eff[15:8] : b_eff[7:0];
            alu_cin = sel_hi & c_lo;
            alu_sub = (op == OP_DEC16);
        end
    end

endmodule

// File: rtl/alu16_seq.sv
// rtl/alu16_seq.sv - 16-bit add/inc/dec/addsp sequenced as two byte passes through a shared 8-bit ALU
module alu16_seq
    import alu16_pkg::*;
(
    input  logic        CLK,
    input  logic        nRESET,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [15:0] opa,
    input  logic [15:0] opb,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        flag_c,
    output logic        flag_h,
    output logic        flags_we,
    output logic        alu_req,
    input  logic        alu_gnt,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic        alu_cin,
    output logic        alu_sub,
    input  logic [7:0]  alu_res,
    input  logic        alu_cout,
    input  logic        alu_hout
);

    state_t      state, state_nx;
    logic [1:0]  op_q;
    logic [15:0] a_q, b_q;
    logic [7:0]  res_lo;
    logic        c_lo, h_lo;

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b1;
        done     = 1'b0;
        alu_req  = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nx = LO;
            end
            LO: begin
                alu_req = 1'b1;
                if (alu_gnt) state_nx = HI;
            end
            HI: begin
                alu_req = 1'b1;
                if (alu_gnt) state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
        endcase
    end

    assign flags_we = done & ((op_q == OP_ADD16) | (op_q == OP_ADDSP));

    // The high-byte capture writes straight into result/flags so they hold across the next op's LO pass.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            op_q   <= OP_ADD16;
            a_q    <= '0;
            b_q    <= '0;
            res_lo <= '0;
            c_lo   <= 1'b0;
            h_lo   <= 1'b0;
            result <= '0;
            flag_c <= 1'b0;
            flag_h <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                op_q <= op;
                a_q  <= opa;
                b_q  <= opb;
            end
            if (state == LO && alu_gnt) begin
                res_lo <= alu_res;
                c_lo   <= alu_cout;
                h_lo   <= alu_hout;
            end
            if (state == HI && alu_gnt) begin
                result <= {alu_res, res_lo};
                flag_c <= (op_q == OP_ADDSP) ? c_lo : alu_cout;
                flag_h <= (op_q == OP_ADDSP) ? h_lo : alu_hout;
            end
        end
    end

    alu16_byte_mux u_byte_mux (
        .active  (state == LO || state == HI),
        .sel_hi  (state == HI),
        .op      (op_q),
        .opa     (a_q),
        .opb     (b_q),
        .c_lo    (c_lo),
        .alu_a   (alu_a),
        .alu_b   (alu_b),
        .alu_cin (alu_cin),
        .alu_sub (alu_sub)
    );

endmodule

// File: tb/tb_alu16_seq.sv
// tb/tb_alu16_seq.sv - directed self-checking bench for alu16_seq with a behavioural shared 8-bit ALU
module tb_alu16_seq;
    import alu16_pkg::*;

    logic        CLK = 1'b0;
    logic        nRESET = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [15:0] opa = '0;
    logic [15:0] opb = '0;
    logic        alu_gnt = 1'b1;
    logic        busy, done, flag_c, flag_h, flags_we;
    logic        alu_req, alu_cin, alu_sub, alu_cout, alu_hout;
    logic [15:0] result;
    logic [7:0]  alu_a, alu_b, alu_res;

    int total = 0;
    int bad = 0;
    int lat;
    int dcount;

    always #5 CLK = ~CLK;

    // Shared byte ALU: add or subtract with carry/borrow out of bits 7 and 3.
    logic [8:0] full;
    logic [4:0] nib;
    assign full = alu_sub ? ({1'b0, alu_a} - {1'b0, alu_b} - {8'd0, alu_cin})
                          : ({1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin});
    assign nib  = alu_sub ? ({1'b0, alu_a[3:0]} - {1'b0, alu_b[3:0]} - {4'd0, alu_cin})
                          : ({1'b0, alu_a[3:0]} + {1'b0, alu_b[3:0]} + {4'd0, alu_cin});
    assign alu_res  = full[7:0];
    assign alu_cout = full[8];
    assign alu_hout = nib[4];

    alu16_seq dut (
        .CLK      (CLK),
        .nRESET   (nRESET),
        .start    (start),
        .op       (op),
        .opa      (opa),
        .opb      (opb),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .flag_c   (flag_c),
        .flag_h   (flag_h),
        .flags_we (flags_we),
        .alu_req  (alu_req),
        .alu_gnt  (alu_gnt),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_cin  (alu_cin),
        .alu_sub  (alu_sub),
        .alu_res  (alu_res),
        .alu_cout (alu_cout),
        .alu_hout (alu_hout)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Inputs are cleared right after acceptance so any later use of them would show up.
    task automatic launch(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
        op = o; opa = a; opb = b; start = 1'b1;
        tick();
        start = 1'b0; op = 2'b00; opa = '0; opb = '0;
    endtask

    task automatic wait_done(input int limit, output int cycles);
        cycles = 1;
        while (!done && cycles < limit) begin
            tick();
            cycles++;
        end
    endtask

    task automatic count_done(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (done) cnt++;
        end
    endtask

    initial begin
        #1;
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_done", 16'(done), 16'd0);
        chk("rst_req", 16'(alu_req), 16'd0);
        chk("rst_result", result, 16'h0000);
        chk("rst_alu_a", 16'(alu_a), 16'h0000);
        tick();
        nRESET = 1'b1;
        tick();

        // ADD16 0x0FFF + 0x0001, minimum latency
        launch(OP_ADD16, 16'h0FFF, 16'h0001);
        chk("add_lo_req", 16'(alu_req), 16'd1);
        chk("add_lo_busy", 16'(busy), 16'd1);
        chk("add_lo_a", 16'(alu_a), 16'h00FF);
        chk("add_lo_b", 16'(alu_b), 16'h0001);
        chk("add_lo_cin", 16'(alu_cin), 16'd0);
        wait_done(20, lat);
        chk("add_latency", 16'(lat), 16'd3);
        chk("add_result", result, 16'h1000);
        chk("add_c", 16'(flag_c), 16'd0);
        chk("add_h", 16'(flag_h), 16'd1);
        chk("add_we", 16'(flags_we), 16'd1);
        tick();
        chk("add_done_clr", 16'(done), 16'd0);
        chk("add_busy_clr", 16'(busy), 16'd0);
        chk("add_hold", result, 16'h1000);
        chk("idle_a_zero", 16'(alu_a), 16'h0000);

        // INC16 0xFFFF wraps
        launch(OP_INC16, 16'hFFFF, 16'h1234);
        wait_done(20, lat);
        chk("inc_latency", 16'(lat), 16'd3);
        chk("inc_result", result, 16'h0000);
        chk("inc_we", 16'(flags_we), 16'd0);
        tick();

        // DEC16 0x0000 wraps, subtract mode in both byte passes
        launch(OP_DEC16, 16'h0000, 16'h5555);
        chk("dec_lo_sub", 16'(alu_sub), 16'd1);
        chk("dec_lo_b", 16'(alu_b), 16'h0001);
        tick();
        chk("dec_hi_sub", 16'(alu_sub), 16'd1);
        chk("dec_hi_b", 16'(alu_b), 16'h0000);
        chk("dec_hi_cin", 16'(alu_cin), 16'd1);
        tick();
        chk("dec_done", 16'(done), 16'd1);
        chk("dec_result", result, 16'hFFFF);
        chk("dec_we", 16'(flags_we), 16'd0);
        chk("dec_done_sub", 16'(alu_sub), 16'd0);
        tick();

        // ADDSP 0x00F8 + (-1); opb upper byte must be ignored
        launch(OP_ADDSP, 16'h00F8, 16'h12FF);
        chk("sp_lo_b", 16'(alu_b), 16'h00FF);
        tick();
        chk("sp_hi_b", 16'(alu_b), 16'h00FF);
        chk("sp_hi_cin", 16'(alu_cin), 16'd1);
        tick();
        chk("sp_done", 16'(done), 16'd1);
        chk("sp_result", result, 16'h00F7);
        chk("sp_c", 16'(flag_c), 16'd1);
        chk("sp_h", 16'(flag_h), 16'd1);
        chk("sp_we", 16'(flags_we), 16'd1);
        tick();

        // Grant withheld 4 cycles in LO and 2 in HI: ABCD + 1357 = BF24
        alu_gnt = 1'b0;
        launch(OP_ADD16, 16'hABCD, 16'h1357);
        lat = 1;
        for (int i = 0; i < 4; i++) begin
            chk("stall_lo_a", 16'(alu_a), 16'h00CD);
            chk("stall_lo_b", 16'(alu_b), 16'h0057);
            tick();
            lat++;
        end
        chk("stall_lo_req", 16'(alu_req), 16'd1);
        alu_gnt = 1'b1;
        tick();
        lat++;
        alu_gnt = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("stall_hi_a", 16'(alu_a), 16'h00AB);
            chk("stall_hi_b", 16'(alu_b), 16'h0013);
            chk("stall_hi_cin", 16'(alu_cin), 16'd1);
            chk("stall_hi_done", 16'(done), 16'd0);
            tick();
            lat++;
        end
        alu_gnt = 1'b1;
        tick();
        lat++;
        chk("stall_latency", 16'(lat), 16'd9);
        chk("stall_done", 16'(done), 16'd1);
        chk("stall_result", result, 16'hBF24);
        chk("stall_c", 16'(flag_c), 16'd0);
        tick();

        // Asynchronous reset while in HI
        launch(OP_ADD16, 16'h1234, 16'h1111);
        tick();
        #2;
        nRESET = 1'b0;
        #1;
        chk("arst_busy", 16'(busy), 16'd0);
        chk("arst_req", 16'(alu_req), 16'd0);
        chk("arst_a", 16'(alu_a), 16'h0000);
        chk("arst_b", 16'(alu_b), 16'h0000);
        chk("arst_cin", 16'(alu_cin), 16'd0);
        chk("arst_result", result, 16'h0000);
        chk("arst_flags", {14'd0, flag_c, flag_h}, 16'd0);
        chk("arst_done", 16'(done), 16'd0);
        tick();
        nRESET = 1'b1;
        count_done(5, dcount);
        chk("arst_no_done", 16'(dcount), 16'd0);
        launch(OP_ADD16, 16'h1234, 16'h1111);
        wait_done(20, lat);
        chk("post_rst_latency", 16'(lat), 16'd3);
        chk("post_rst_result", result, 16'h2345);
        tick();

        // start pulsed while in LO and while in DONE must be dropped
        launch(OP_ADD16, 16'h0001, 16'h0002);
        op = OP_INC16; opa = 16'hFFFF; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("ign_done", 16'(done), 16'd1);
        chk("ign_result", result, 16'h0003);
        op = OP_INC16; opa = 16'h0005; start = 1'b1;
        tick();
        start = 1'b0;
        chk("ign_busy", 16'(busy), 16'd0);
        count_done(6, dcount);
        chk("ign_no_extra_done", 16'(dcount), 16'd0);
        chk("ign_hold", result, 16'h0003);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
